// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order and the
// hex glyph table, stored in active-low form (0 = segment lit).
package seg7_pkg;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int SEG_W = int'(SEG_G) + 1;

  typedef logic [SEG_W-1:0] seg_t;

  // Index is the hex value; bit 0 is segment a, bit 6 is segment g.
  localparam seg_t GLYPH_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_glyph
);

  assign o_glyph = GLYPH_AL[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver: double-buffered hex display with
// per-slot blanking, optional leading-zero suppression and registered outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_en,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  pend,
  output logic                  frame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // XOR masks turning active-high internal values into the pin polarity;
  // they double as the inactive (idle) pin levels.
  localparam seg_t              SEG_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIGITS-1:0] DIG_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic              DP_IDLE  = (ACTIVE_LOW != 0);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_act_val, r_sh_val;
  logic [DIGITS-1:0]     r_act_dp, r_sh_dp;
  logic                  r_pend, r_frame;
  seg_t                  r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_dig;

  logic                  w_tick, w_frame_start, w_blank, w_supp;
  logic [3:0]            w_nib;
  seg_t                  w_glyph_al, w_seg_hi;
  logic                  w_dp_hi;
  logic [DIGITS-1:0]     w_dig_hi;
  logic [DIGITS:0]       w_zero_from;

  assign w_tick        = (r_cnt == CNT_LAST);
  assign w_frame_start = w_tick && (r_idx == IDX_LAST);
  assign w_blank       = (r_cnt < CNT_BLANK);
  assign w_nib         = r_act_val[{r_idx, 2'b00} +: 4];

  seg7_hexdec u_hexdec (
    .i_nib   (w_nib),
    .o_glyph (w_glyph_al)
  );

  // w_zero_from[i] is set when active nibbles DIGITS-1..i are all zero.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it holding state (no latch).
  always_comb begin
    w_zero_from         = '0;
    w_zero_from[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_from[i] = w_zero_from[i+1] && (r_act_val[4*i +: 4] == 4'h0);
    end
  end

  assign w_supp   = lz_en && (r_idx != '0) && w_zero_from[r_idx];
  assign w_seg_hi = (w_blank || w_supp) ? '0 : ~w_glyph_al;
  assign w_dp_hi  = !w_blank && r_act_dp[r_idx];
  assign w_dig_hi = w_blank ? '0 : (DIGITS'(1) << r_idx);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_pend    <= 1'b0;
      r_frame   <= 1'b0;
      r_seg     <= SEG_IDLE;
      r_dp      <= DP_IDLE;
      r_dig     <= DIG_IDLE;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      r_frame <= w_frame_start;

      if (w_frame_start && r_pend) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
      end

      // A load on the frame-start cycle refills the shadow after the
      // transfer above, so pend stays set for the next frame.
      if (load) begin
        r_sh_val <= value;
        r_sh_dp  <= dp;
        r_pend   <= 1'b1;
      end else if (w_frame_start) begin
        r_pend   <= 1'b0;
      end

      r_seg <= w_seg_hi ^ SEG_IDLE;
      r_dp  <= w_dp_hi  ^ DP_IDLE;
      r_dig <= w_dig_hi ^ DIG_IDLE;
    end
  end

  assign seg     = r_seg;
  assign dp_out  = r_dp;
  assign dig_sel = r_dig;
  assign pend    = r_pend;
  assign frame   = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus queues the expected glyph of each
// digit slot, a negedge monitor pops and compares as each slot lights up.
module tb_seg7_scan;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 16;
  localparam int BLANK_CYC = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        pend;
  logic        frame;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .ACTIVE_LOW (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (value),
    .dp      (dp),
    .lz_en   (lz_en),
    .seg     (seg),
    .dp_out  (dp_out),
    .dig_sel (dig_sel),
    .pend    (pend),
    .frame   (frame)
  );

  // Counts rising edges since reset release: after edge En, cyc = n+1.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic at_edge(input int n);
    int guard = 0;
    while (cyc != n + 1 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n + 1) check("at_edge_timeout", cyc, n + 1);
  endtask

  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] d);
    at_edge(n - 1);
    load  = 1'b1;
    value = v;
    dp    = d;
    at_edge(n);
    load  = 1'b0;
  endtask

  // Expected glyphs for digits 0..3 and the expected dp_out pin per digit.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpo);
    sb.push_back('{dig: 4'hE, seg: s0, dp: dpo[0]});
    sb.push_back('{dig: 4'hD, seg: s1, dp: dpo[1]});
    sb.push_back('{dig: 4'hB, seg: s2, dp: dpo[2]});
    sb.push_back('{dig: 4'h7, seg: s3, dp: dpo[3]});
  endtask

  // Monitor: one scoreboard entry per lit slot, slot length and stability
  // checked when the slot goes dark, frame spacing checked on each pulse.
  logic [3:0] prev_dig  = 4'hF;
  logic       prev_frm  = 1'b0;
  exp_t       cur       = '0;
  int         run_len   = 0;
  bit         run_bad   = 0;
  bit         aborted   = 0;
  bit         have_last = 0;
  int         ncyc      = 0;
  int         last_frm  = 0;

  always @(negedge clk) begin
    ncyc++;
    if (dig_sel != 4'hF) begin
      if (prev_dig == 4'hF) begin
        aborted = 0;
        run_len = 0;
        run_bad = 0;
        if (sb.size() == 0) begin
          check("sb_unexpected_slot", {28'd0, dig_sel}, 32'hF);
        end else begin
          cur = sb.pop_front();
          check("slot_dig", {28'd0, dig_sel}, {28'd0, cur.dig});
          check("slot_seg", {25'd0, seg}, {25'd0, cur.seg});
          check("slot_dp", {31'd0, dp_out}, {31'd0, cur.dp});
        end
      end else if ({dig_sel, seg, dp_out} != {cur.dig, cur.seg, cur.dp}) begin
        run_bad = 1;
      end
      run_len++;
    end else if (prev_dig != 4'hF) begin
      if (!aborted) begin
        check("slot_len", run_len, SCAN_DIV - BLANK_CYC);
        check("slot_stable", {31'd0, run_bad}, 32'd0);
      end
      aborted = 0;
    end

    if (frame) begin
      check("frame_width", {31'd0, prev_frm}, 32'd0);
      if (have_last) check("frame_period", ncyc - last_frm, DIGITS * SCAN_DIV);
      have_last = 1;
      last_frm  = ncyc;
    end

    if (!rst_n) begin
      aborted   = 1;
      have_last = 0;
    end
    prev_dig = dig_sel;
    prev_frm = frame;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Frame 0 shows the cleared active buffer.
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);

    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dig", {28'd0, dig_sel}, 32'hF);
    check("reset_dp", {31'd0, dp_out}, 32'd1);
    check("reset_pend", {31'd0, pend}, 32'd0);
    check("reset_frame", {31'd0, frame}, 32'd0);
    rst_n = 1'b1;

    do_load(10, 16'h12AF, 4'b0010);
    check("pend_after_load", {31'd0, pend}, 32'd1);
    push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b1101);

    at_edge(62);
    check("pend_hold", {31'd0, pend}, 32'd1);
    check("frame_before", {31'd0, frame}, 32'd0);
    at_edge(63);
    check("frame_pulse", {31'd0, frame}, 32'd1);
    check("pend_cleared", {31'd0, pend}, 32'd0);
    at_edge(64);
    check("frame_after", {31'd0, frame}, 32'd0);

    // Two loads in one frame: only the second is ever displayed.
    do_load(70, 16'h1111, 4'b0000);
    do_load(80, 16'h2222, 4'b0000);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);

    do_load(150, 16'h0030, 4'b0101);
    check("pend_second", {31'd0, pend}, 32'd1);
    at_edge(185);
    lz_en = 1'b1;

    // Load landing on the frame-start edge: 0030 goes active, 8000 waits.
    do_load(191, 16'h8000, 4'b1000);
    check("pend_on_frame_load", {31'd0, pend}, 32'd1);
    push_frame(7'h40, 7'h30, 7'h7F, 7'h7F, 4'b1010);
    push_frame(7'h40, 7'h40, 7'h40, 7'h00, 4'b0111);
    sb.push_back('{dig: 4'hE, seg: 7'h40, dp: 1'b1});
    sb.push_back('{dig: 4'hD, seg: 7'h40, dp: 1'b1});
    sb.push_back('{dig: 4'hB, seg: 7'h40, dp: 1'b1});

    at_edge(255);
    check("pend_after_transfer", {31'd0, pend}, 32'd0);
    check("frame_pulse_4", {31'd0, frame}, 32'd1);

    // Reset during digit 2 with data pending.
    do_load(330, 16'h9999, 4'b1111);
    at_edge(359);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    check("midrst_dig", {28'd0, dig_sel}, 32'hF);
    check("midrst_dp", {31'd0, dp_out}, 32'd1);
    check("midrst_pend", {31'd0, pend}, 32'd0);
    check("midrst_frame", {31'd0, frame}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);

    at_edge(63);
    check("restart_frame", {31'd0, frame}, 32'd1);
    check("restart_pend", {31'd0, pend}, 32'd0);
    at_edge(65);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; SHALL be in the range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; SHALL be at least 4.
REQ-003 Parameter BLANK_CYC, default 8: all-off cycles at the start of each slot (anti-ghosting); SHALL be less than SCAN_DIV.
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, seg, dp_out and dig_sel are driven active-low; when 0, active-high.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 load  in  1  single-cycle strobe; captures value and dp into the shadow register.
REQ-008 value  in  4*DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-009 dp  in  DIGITS  decimal-point request per digit.
REQ-010 lz_en  in  1  enables leading-zero suppression; sampled live, not shadowed.
REQ-011 seg  out  7  segment drive, bit0=a through bit6=g.
REQ-012 dp_out  out  1  decimal-point drive for the currently selected digit.
REQ-013 dig_sel  out  DIGITS  one-hot digit select.
REQ-014 pend  out  1  high while shadow data is waiting to be displayed.
REQ-015 frame  out  1  one-cycle pulse when digit slot 0 begins.

Function
REQ-016 Prescaler: counts 0..SCAN_DIV-1 and wraps; tick is asserted when the count equals SCAN_DIV-1.
REQ-017 Digit index: advances on tick; wraps from DIGITS-1 to 0.
REQ-018 Frame start: the tick on which the index wraps to 0; this cycle SHALL produce the frame pulse and the shadow-to-active transfer.
REQ-019 Double buffering: active <= shadow at frame start if pend=1, and pend clears on that same cycle.
REQ-020 Load with pend=1: the newest load overwrites the shadow (last write wins).
REQ-021 Load on the frame-start cycle: the old shadow moves to active, the new data enters the shadow, and pend stays 1.
REQ-022 Slot blanking: while the prescaler count is below BLANK_CYC, seg, dp_out and dig_sel SHALL all be inactive.
REQ-023 Outside blanking: dig_sel activates only the bit for the current index, and seg shows the decode of that active nibble.
REQ-024 Active-low decode table, hex 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
REQ-025 ACTIVE_LOW=0 output SHALL be the bitwise inverse of the REQ-024 table.
REQ-026 Leading-zero suppression: with lz_en=1, digit i>0 shows all segments off when nibbles DIGITS-1..i are all zero; digit 0 is never suppressed.
REQ-027 dp_out follows the active dp bit of the current digit, including on suppressed digits.
REQ-028 seg, dp_out, dig_sel and frame SHALL be registered: one cycle of latency from prescaler/index state.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL clear prescaler, index, active, shadow, pend and frame.
REQ-030 On that same edge, seg, dp_out and dig_sel SHALL go inactive, and they SHALL stay inactive until the first non-blank cycle.
REQ-031 Reset mid-frame abandons the frame, and scanning restarts at digit 0 with count 0.

Structure
REQ-032 Package seg7_pkg SHALL hold the REQ-024 glyph table constant and the segment bit-order constants.
REQ-033 Sub-module seg7_hexdec SHALL be a combinational nibble-to-glyph decoder, instantiated once on the muxed nibble.

Verification
REQ-034 The bench SHALL use DIGITS=4, SCAN_DIV=16, BLANK_CYC=2 and cover the following directed scenarios.
REQ-035 Reset: hold rst_n=0 for 3 cycles -> seg=7F, dig_sel=F, pend=0, frame=0.
REQ-036 Scan order: free-run -> dig_sel active on digit 0,1,2,3,0, each slot 16 cycles with the first 2 all-off; frame pulses every 64 cycles.
REQ-037 Load: load value=12AF -> pend=1 until frame start; then digits 0..3 show 0E, 08, 24, 79.
REQ-038 Suppression: lz_en=1, value=0030 -> digits 3 and 2 off; digit 1 shows 30; digit 0 shows 40.
REQ-039 Last write wins: loads of 1111 then 2222 within one frame -> only 2222 displayed; a load on the frame-start cycle -> pend remains 1.
REQ-040 Reset mid-scan: assert rst_n=0 during digit 2 -> outputs inactive next cycle, pend=0; after release, the scan restarts at digit 0.
